// File: rtl/chimera_wide_route_ctrl.sv
// chimera_wide_route_ctrl
// Control plane for the cluster's wide AXI out port. It sits beside the wide
// AXI demux and drives that demux's select inputs.
//
// What it does:
//   - Decodes each AW/AR address to an output port index. Port 0 is the
//     default SoC path; ports 1..NumRegions are the pass-through regions.
//   - Gates the AW/AR address handshakes.
//   - Counts outstanding writes and reads.
//   - Applies a change of bypass mode only after all in-flight wide traffic
//     has retired, so a select never changes under an outstanding
//     transaction.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   bypass_req_i            requested mode (1 = every transaction to port 0)
//   bypass_active_o         mode currently applied (registered)
//   switch_busy_o           drain/switch in progress (registered)
//   aw_valid_i, aw_addr_i   upstream AW request
//   aw_ready_o              upstream AW ready (gated, combinational)
//   aw_valid_o              downstream AW valid (gated, combinational)
//   aw_ready_i              downstream AW ready
//   aw_sel_o                AW port select (combinational)
//   ar_*                    same set for AR
//   b_done_i, r_done_i      one write / one read retired this cycle
//   aw_cnt_o, ar_cnt_o      outstanding writes / reads (registered)
//   err_o                   sticky: a retire was seen while the count was 0
module chimera_wide_route_ctrl #(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned NumRegions = 2,
  parameter int unsigned MaxTxn     = 8,
  parameter logic [AddrWidth-1:0] RegionStart [NumRegions] = '{default: '0},
  parameter logic [AddrWidth-1:0] RegionEnd   [NumRegions] = '{default: '0},
  parameter int unsigned SelWidth   = $clog2(NumRegions + 1),
  parameter int unsigned CntWidth   = $clog2(MaxTxn + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bypass_req_i,
  output logic                 bypass_active_o,
  output logic                 switch_busy_o,
  input  logic                 aw_valid_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  output logic                 aw_ready_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [SelWidth-1:0]  aw_sel_o,
  input  logic                 ar_valid_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  output logic                 ar_ready_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [SelWidth-1:0]  ar_sel_o,
  input  logic                 b_done_i,
  input  logic                 r_done_i,
  output logic [CntWidth-1:0]  aw_cnt_o,
  output logic [CntWidth-1:0]  ar_cnt_o,
  output logic                 err_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxn);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StSwitch = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic aw_gate, ar_gate;
  logic aw_accept, ar_accept;

  // Region decode.
  // The lowest-indexed matching region wins.
  // An empty region (start >= end) never matches.
  function automatic logic [SelWidth-1:0] decode(input logic [AddrWidth-1:0] addr);
    logic [SelWidth-1:0] sel;
    sel = '0;
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      if ((RegionStart[i] < RegionEnd[i]) &&
          (addr >= RegionStart[i]) && (addr < RegionEnd[i])) begin
        sel = SelWidth'(i + 1);
      end
    end
    return sel;
  endfunction

  // In bypass mode every transaction goes to the default SoC port.
  assign aw_sel_o = bypass_active_o ? '0 : decode(aw_addr_i);
  assign ar_sel_o = bypass_active_o ? '0 : decode(ar_addr_i);

  // Handshake gating.
  // Traffic is closed outside RUN, and while a channel is at its outstanding limit.
  assign aw_gate    = (state_q == StRun) && (aw_cnt_o < CntMax);
  assign ar_gate    = (state_q == StRun) && (ar_cnt_o < CntMax);
  assign aw_valid_o = aw_valid_i & aw_gate;
  assign aw_ready_o = aw_ready_i & aw_gate;
  assign ar_valid_o = ar_valid_i & ar_gate;
  assign ar_ready_o = ar_ready_i & ar_gate;
  assign aw_accept  = aw_valid_i & aw_ready_i & aw_gate;
  assign ar_accept  = ar_valid_i & ar_ready_i & ar_gate;

  // Next-state logic for the mode-switch FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (bypass_req_i != bypass_active_o) state_d = StDrain;
      end
      StDrain: begin
        // A withdrawn request cancels the drain without touching the mode.
        if (bypass_req_i == bypass_active_o)            state_d = StRun;
        else if ((aw_cnt_o == '0) && (ar_cnt_o == '0))  state_d = StSwitch;
      end
      StSwitch: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // State register plus registered mode and busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StRun;
      bypass_active_o <= 1'b0;
      switch_busy_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      switch_busy_o <= (state_d != StRun);
      if (state_q == StSwitch) bypass_active_o <= bypass_req_i;
    end
  end

  // Outstanding write counter.
  // An accept and a retire in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_cnt_o <= '0;
    end else if (aw_accept && !b_done_i) begin
      aw_cnt_o <= aw_cnt_o + CntWidth'(1);
    end else if (!aw_accept && b_done_i && (aw_cnt_o != '0)) begin
      aw_cnt_o <= aw_cnt_o - CntWidth'(1);
    end
  end

  // Outstanding read counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_cnt_o <= '0;
    end else if (ar_accept && !r_done_i) begin
      ar_cnt_o <= ar_cnt_o + CntWidth'(1);
    end else if (!ar_accept && r_done_i && (ar_cnt_o != '0)) begin
      ar_cnt_o <= ar_cnt_o - CntWidth'(1);
    end
  end

  // Sticky error.
  // Set when a retire arrives with nothing outstanding and no accept to pair it with.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if ((b_done_i && !aw_accept && (aw_cnt_o == '0)) ||
                 (r_done_i && !ar_accept && (ar_cnt_o == '0))) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chimera_wide_route_ctrl.sv
// Testbench for chimera_wide_route_ctrl.
// Region decode is checked from a table of vectors. The multi-cycle corner
// cases (limit, drain/switch, cancel, same-cycle accept+retire, async reset)
// are checked with short hand-written sequences.
module tb_chimera_wide_route_ctrl;

  localparam int unsigned AddrW = 48;
  localparam int unsigned NReg  = 2;
  localparam int unsigned MaxT  = 8;
  localparam int unsigned SelW  = 2;
  localparam int unsigned CntW  = 4;
  localparam logic [AddrW-1:0] RStart [NReg] = '{48'h1000, 48'h1800};
  localparam logic [AddrW-1:0] REnd   [NReg] = '{48'h2000, 48'h3000};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bypass_req;
  logic             bypass_active, switch_busy;
  logic             aw_valid_in, aw_ready_out, aw_valid_out, aw_ready_in;
  logic [AddrW-1:0] aw_addr;
  logic [SelW-1:0]  aw_sel;
  logic             ar_valid_in, ar_ready_out, ar_valid_out, ar_ready_in;
  logic [AddrW-1:0] ar_addr;
  logic [SelW-1:0]  ar_sel;
  logic             b_done, r_done;
  logic [CntW-1:0]  aw_cnt, ar_cnt;
  logic             err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chimera_wide_route_ctrl #(
    .AddrWidth  (AddrW),
    .NumRegions (NReg),
    .MaxTxn     (MaxT),
    .RegionStart(RStart),
    .RegionEnd  (REnd)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bypass_req_i   (bypass_req),
    .bypass_active_o(bypass_active),
    .switch_busy_o  (switch_busy),
    .aw_valid_i     (aw_valid_in),
    .aw_addr_i      (aw_addr),
    .aw_ready_o     (aw_ready_out),
    .aw_valid_o     (aw_valid_out),
    .aw_ready_i     (aw_ready_in),
    .aw_sel_o       (aw_sel),
    .ar_valid_i     (ar_valid_in),
    .ar_addr_i      (ar_addr),
    .ar_ready_o     (ar_ready_out),
    .ar_valid_o     (ar_valid_out),
    .ar_ready_i     (ar_ready_in),
    .ar_sel_o       (ar_sel),
    .b_done_i       (b_done),
    .r_done_i       (r_done),
    .aw_cnt_o       (aw_cnt),
    .ar_cnt_o       (ar_cnt),
    .err_o          (err)
  );

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [SelW-1:0]  sel;
  } dec_vec_t;

  dec_vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bypass_req  = 1'b0;
    aw_valid_in = 1'b0; aw_ready_in = 1'b0; aw_addr = '0;
    ar_valid_in = 1'b0; ar_ready_in = 1'b0; ar_addr = '0;
    b_done = 1'b0; r_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{48'h0FFF,        2'd0};
    vecs[1] = '{48'h1000,        2'd1};
    vecs[2] = '{48'h1800,        2'd1};
    vecs[3] = '{48'h1FFF,        2'd1};
    vecs[4] = '{48'h2000,        2'd2};
    vecs[5] = '{48'h2800,        2'd2};
    vecs[6] = '{48'h2FFF,        2'd2};
    vecs[7] = '{48'h3000,        2'd0};
    vecs[8] = '{48'hFFFF_0000_1800, 2'd0};

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_bypass", 64'(bypass_active), 64'd0);
    chk("rst_busy",   64'(switch_busy),   64'd0);
    chk("rst_awcnt",  64'(aw_cnt),        64'd0);
    chk("rst_arcnt",  64'(ar_cnt),        64'd0);
    chk("rst_err",    64'(err),           64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Decode table: valid high, downstream ready low, so nothing is accepted.
    for (int i = 0; i < 9; i++) begin
      aw_valid_in = 1'b1; aw_addr = vecs[i].addr;
      ar_valid_in = 1'b1; ar_addr = vecs[i].addr;
      #1;
      chk($sformatf("aw_sel[%0d]", i), 64'(aw_sel), 64'(vecs[i].sel));
      chk($sformatf("ar_sel[%0d]", i), 64'(ar_sel), 64'(vecs[i].sel));
      tick();
    end
    chk("dec_vld_o",  64'(aw_valid_out), 64'd1);
    chk("dec_rdy_o",  64'(aw_ready_out), 64'd0);
    chk("dec_awcnt",  64'(aw_cnt),       64'd0);
    idle_inputs();

    // AR limit: 8 accepts fill the channel, then it closes.
    ar_valid_in = 1'b1; ar_ready_in = 1'b1; ar_addr = 48'h1000;
    repeat (8) tick();
    chk("lim_cnt8",   64'(ar_cnt),       64'd8);
    chk("lim_rdy0",   64'(ar_ready_out), 64'd0);
    chk("lim_vld0",   64'(ar_valid_out), 64'd0);
    tick();
    chk("lim_hold8",  64'(ar_cnt),       64'd8);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    chk("lim_cnt7",   64'(ar_cnt),       64'd7);
    #1;
    chk("lim_rdy1",   64'(ar_ready_out), 64'd1);
    tick();
    chk("lim_reacc",  64'(ar_cnt),       64'd8);
    ar_valid_in = 1'b0;
    r_done = 1'b1;
    repeat (8) tick();
    r_done = 1'b0;
    chk("lim_drain0", 64'(ar_cnt),       64'd0);
    chk("lim_err0",   64'(err),          64'd0);

    // Same-cycle accept + retire, then a retire with nothing outstanding.
    aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    repeat (2) tick();
    chk("same_cnt2",  64'(aw_cnt), 64'd2);
    b_done = 1'b1;
    tick();
    chk("same_hold2", 64'(aw_cnt), 64'd2);
    aw_valid_in = 1'b0;
    repeat (2) tick();
    chk("same_cnt0",  64'(aw_cnt), 64'd0);
    chk("same_err0",  64'(err),    64'd0);
    tick();
    b_done = 1'b0;
    chk("under_cnt",  64'(aw_cnt), 64'd0);
    chk("under_err",  64'(err),    64'd1);
    tick();
    chk("err_sticky", 64'(err),    64'd1);
    do_reset();
    chk("err_clr",    64'(err),    64'd0);

    // Drain with 3 writes outstanding, then a one-cycle switch into bypass.
    aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    repeat (3) tick();
    aw_valid_in = 1'b0;
    chk("drn_cnt3",   64'(aw_cnt),      64'd3);
    bypass_req = 1'b1;
    tick();
    chk("drn_busy",   64'(switch_busy), 64'd1);
    aw_valid_in = 1'b1; ar_valid_in = 1'b1; ar_ready_in = 1'b1;
    #1;
    chk("drn_awv",    64'(aw_valid_out), 64'd0);
    chk("drn_awr",    64'(aw_ready_out), 64'd0);
    chk("drn_arv",    64'(ar_valid_out), 64'd0);
    tick();
    chk("drn_hold3",  64'(aw_cnt), 64'd3);
    chk("drn_ar0",    64'(ar_cnt), 64'd0);
    aw_valid_in = 1'b0; ar_valid_in = 1'b0;
    b_done = 1'b1;
    repeat (3) tick();
    b_done = 1'b0;
    chk("drn_cnt0",   64'(aw_cnt),        64'd0);
    chk("drn_busy2",  64'(switch_busy),   64'd1);
    chk("drn_mode0",  64'(bypass_active), 64'd0);
    tick();
    chk("sw_busy",    64'(switch_busy),   64'd1);
    chk("sw_mode0",   64'(bypass_active), 64'd0);
    tick();
    chk("sw_mode1",   64'(bypass_active), 64'd1);
    chk("sw_busy0",   64'(switch_busy),   64'd0);
    aw_addr = 48'h1800; ar_addr = 48'h2800;
    aw_valid_in = 1'b1; aw_ready_in = 1'b1;
    #1;
    chk("byp_awsel",  64'(aw_sel),       64'd0);
    chk("byp_arsel",  64'(ar_sel),       64'd0);
    chk("byp_open",   64'(aw_valid_out), 64'd1);

    // Reset in the middle of a drain back out of bypass.
    tick();
    tick();
    aw_valid_in = 1'b0;
    ar_valid_in = 1'b1;
    tick();
    ar_valid_in = 1'b0;
    chk("rd_aw2",     64'(aw_cnt), 64'd2);
    chk("rd_ar1",     64'(ar_cnt), 64'd1);
    bypass_req = 1'b0;
    tick();
    chk("rd_busy",    64'(switch_busy),   64'd1);
    chk("rd_mode1",   64'(bypass_active), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rd_rbyp",    64'(bypass_active), 64'd0);
    chk("rd_rbusy",   64'(switch_busy),   64'd0);
    chk("rd_raw",     64'(aw_cnt),        64'd0);
    chk("rd_rar",     64'(ar_cnt),        64'd0);
    chk("rd_rerr",    64'(err),           64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // A drain cancelled by withdrawing the request.
    aw_valid_in = 1'b1; aw_ready_in = 1'b1; aw_addr = 48'h1800;
    repeat (2) tick();
    aw_valid_in = 1'b0;
    bypass_req = 1'b1;
    tick();
    chk("cx_busy",    64'(switch_busy), 64'd1);
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    chk("cx_cnt1",    64'(aw_cnt), 64'd1);
    bypass_req = 1'b0;
    tick();
    chk("cx_busy0",   64'(switch_busy),   64'd0);
    chk("cx_mode0",   64'(bypass_active), 64'd0);
    aw_valid_in = 1'b1;
    #1;
    chk("cx_open",    64'(aw_valid_out), 64'd1);
    chk("cx_sel",     64'(aw_sel),       64'd1);
    tick();
    aw_valid_in = 1'b0;
    chk("cx_cnt2",    64'(aw_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
